// File: rtl/rf_pkg.sv
//------------------------------------------------------------------------------
// rf_pkg : shared sizes, types and helpers for the register-file read side.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rf_pkg;

  localparam int REG_ID_W   = 4;
  localparam int NUM_REGS   = 16;
  localparam int DEF_DATA_W = 16;

  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [NUM_REGS-1:0] wordline_t;

  // True when more than one wordline bit is high (clearing the lowest set bit leaves something).
  function automatic logic multi_hot(input wordline_t wl);
    return (wl & (wl - wordline_t'(1))) != '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_read_mux.sv
//------------------------------------------------------------------------------
// rf_read_mux : 16:1 register select with optional write bypass and R0 masking.
// Optional feature macro: RF_WRITE_BYPASS_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rf_read_mux
  import rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ZERO_R0 = 0
) (
  input  logic [NUM_REGS*DATA_W-1:0] rf_flat,
  input  logic [REG_ID_W-1:0]        sel,
  input  logic [NUM_REGS-1:0]        wordline,
  input  logic [DATA_W-1:0]          dst_data,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] w_sel_data;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == reg_id_t'(i)) begin
        w_sel_data = rf_flat[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  logic [DATA_W-1:0] w_byp_data;

  always_comb begin
    w_byp_data = w_sel_data;
    if (wordline[sel]) begin
      w_byp_data = dst_data;
    end
  end
`else
  logic [DATA_W-1:0] w_byp_data;
  logic              w_unused_byp;

  assign w_byp_data   = w_sel_data;
  assign w_unused_byp = ^{wordline, dst_data};
`endif

  // R0 masking sits after the bypass so a same-edge write to R0 never leaks out.
  always_comb begin
    rd_data = w_byp_data;
    if ((ZERO_R0 != 0) && (sel == '0)) begin
      rd_data = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_read_port_unit.sv
//------------------------------------------------------------------------------
// rf_read_port_unit : 16-entry register file with two registered read ports.
// Optional feature macro: RF_WRITE_BYPASS_EN. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rf_read_port_unit
  import rf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       wordline,
  input  logic [DATA_W-1:0] dst_data,
  input  logic [3:0]        src_reg1,
  input  logic [3:0]        src_reg2,
  input  logic              rd_req,
  input  logic              stall,
  output logic [DATA_W-1:0] src_data1,
  output logic [DATA_W-1:0] src_data2,
  output logic              rd_valid,
  output logic              onehot_err
);

  logic [NUM_REGS*DATA_W-1:0] r_rf;
  logic [DATA_W-1:0]          r_src_data1;
  logic [DATA_W-1:0]          r_src_data2;
  logic                       r_rd_valid;
  logic                       r_onehot_err;
  logic [NUM_REGS-1:0]        w_we;
  logic [DATA_W-1:0]          w_rd1;
  logic [DATA_W-1:0]          w_rd2;

  // R0 keeps its wordline bit for the one-hot check but never stores when hardwired.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_we
    if ((ZERO_R0 != 0) && (i == 0)) begin : g_r0_ro
      assign w_we[i] = 1'b0;
    end else begin : g_rw
      assign w_we[i] = wordline[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_we[i]) begin
          r_rf[i*DATA_W +: DATA_W] <= dst_data;
        end
      end
    end
  end

  rf_read_mux #(
    .DATA_W  (DATA_W),
    .ZERO_R0 (ZERO_R0)
  ) u_mux1 (
    .rf_flat  (r_rf),
    .sel      (src_reg1),
    .wordline (wordline),
    .dst_data (dst_data),
    .rd_data  (w_rd1)
  );

  rf_read_mux #(
    .DATA_W  (DATA_W),
    .ZERO_R0 (ZERO_R0)
  ) u_mux2 (
    .rf_flat  (r_rf),
    .sel      (src_reg2),
    .wordline (wordline),
    .dst_data (dst_data),
    .rd_data  (w_rd2)
  );

  // Stall freezes the whole read side, including a valid that is already high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_data1 <= '0;
      r_src_data2 <= '0;
      r_rd_valid  <= 1'b0;
    end else if (!stall) begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_src_data1 <= w_rd1;
        r_src_data2 <= w_rd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_onehot_err <= 1'b0;
    end else if (multi_hot(wordline)) begin
      r_onehot_err <= 1'b1;
    end
  end

  assign src_data1  = r_src_data1;
  assign src_data2  = r_src_data2;
  assign rd_valid   = r_rd_valid;
  assign onehot_err = r_onehot_err;

endmodule

`default_nettype wire

// File: tb/tb_rf_read_port_unit.sv
//------------------------------------------------------------------------------
// tb_rf_read_port_unit : directed table, corner sequences and random run
// against a behavioural model, for ZERO_R0 = 0 (dut a) and ZERO_R0 = 1 (dut b).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rf_read_port_unit;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wordline = '0;
  logic [15:0] dst_data = '0;
  logic [3:0]  src_reg1 = '0;
  logic [3:0]  src_reg2 = '0;
  logic        rd_req = 1'b0;
  logic        stall = 1'b0;

  logic [15:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_v, a_e, b_v, b_e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_read_port_unit #(.DATA_W(16), .ZERO_R0(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wordline(wordline), .dst_data(dst_data),
    .src_reg1(src_reg1), .src_reg2(src_reg2), .rd_req(rd_req), .stall(stall),
    .src_data1(a_d1), .src_data2(a_d2), .rd_valid(a_v), .onehot_err(a_e)
  );

  rf_read_port_unit #(.DATA_W(16), .ZERO_R0(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wordline(wordline), .dst_data(dst_data),
    .src_reg1(src_reg1), .src_reg2(src_reg2), .rd_req(rd_req), .stall(stall),
    .src_data1(b_d1), .src_data2(b_d2), .rd_valid(b_v), .onehot_err(b_e)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: index 0 = ZERO_R0 off, index 1 = ZERO_R0 on.
  logic [15:0] m_mem [2][16];
  logic [15:0] m_d1 [2];
  logic [15:0] m_d2 [2];
  logic        m_v [2];
  logic        m_e [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
      m_d1[k] = '0; m_d2[k] = '0; m_v[k] = 1'b0; m_e[k] = 1'b0;
    end
  endtask

  function automatic logic [15:0] m_read(input int k, input logic [3:0] id);
    if (k == 1 && id == 4'd0) return 16'h0000;
    if (BYP && wordline[id]) return dst_data;
    return m_mem[k][id];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!stall) begin
        m_v[k] = rd_req;
        if (rd_req) begin
          m_d1[k] = m_read(k, src_reg1);
          m_d2[k] = m_read(k, src_reg2);
        end
      end
      for (int i = 0; i < 16; i++)
        if (wordline[i] && !(k == 1 && i == 0)) m_mem[k][i] = dst_data;
      if ($countones(wordline) > 1) m_e[k] = 1'b1;
    end
  endtask

  task automatic check_model();
    chk ("a.src_data1", a_d1, m_d1[0]);
    chk ("a.src_data2", a_d2, m_d2[0]);
    chk1("a.rd_valid", a_v, m_v[0]);
    chk1("a.onehot_err", a_e, m_e[0]);
    chk ("b.src_data1", b_d1, m_d1[1]);
    chk ("b.src_data2", b_d2, m_d2[1]);
    chk1("b.rd_valid", b_v, m_v[1]);
    chk1("b.onehot_err", b_e, m_e[1]);
  endtask

  task automatic drive(input logic [15:0] wl, input logic [15:0] dd, input logic [3:0] r1,
                       input logic [3:0] r2, input logic req, input logic st);
    wordline = wl; dst_data = dd; src_reg1 = r1; src_reg2 = r2; rd_req = req; stall = st;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  typedef struct packed {
    logic [15:0] wl;
    logic [15:0] dd;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic        req;
    logic        st;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        ev;
    logic        ee;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [15:0] wl, input logic [15:0] dd, input logic [3:0] r1,
                              input logic [3:0] r2, input logic req, input logic st,
                              input logic [15:0] e1, input logic [15:0] e2,
                              input logic ev, input logic ee);
    vec_t v;
    v.wl = wl; v.dd = dd; v.r1 = r1; v.r2 = r2; v.req = req; v.st = st;
    v.e1 = e1; v.e2 = e2; v.ev = ev; v.ee = ee;
    return v;
  endfunction

  initial begin
    logic [15:0] same_edge_r7;
    same_edge_r7 = BYP ? 16'h2222 : 16'h1111;
    // Expected values are for the ZERO_R0 = 0 instance, starting from reset.
    tbl[0]  = mk(16'h0008, 16'hBEEF, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    tbl[1]  = mk(16'h0000, 16'h0000, 4'd3, 4'd3, 1'b1, 1'b0, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0);
    tbl[2]  = mk(16'h0000, 16'h0000, 4'd3, 4'd3, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
    tbl[3]  = mk(16'h0080, 16'h1111, 4'd0, 4'd0, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
    tbl[4]  = mk(16'h0080, 16'h2222, 4'd7, 4'd3, 1'b1, 1'b0, same_edge_r7, 16'hBEEF, 1'b1, 1'b0);
    tbl[5]  = mk(16'h0000, 16'h0000, 4'd7, 4'd7, 1'b1, 1'b0, 16'h2222, 16'h2222, 1'b1, 1'b0);
    tbl[6]  = mk(16'h0020, 16'h00AA, 4'd0, 4'd0, 1'b0, 1'b0, 16'h2222, 16'h2222, 1'b0, 1'b0);
    tbl[7]  = mk(16'h0000, 16'h0000, 4'd5, 4'd3, 1'b1, 1'b0, 16'h00AA, 16'hBEEF, 1'b1, 1'b0);
    tbl[8]  = mk(16'h0002, 16'h5555, 4'd1, 4'd1, 1'b1, 1'b1, 16'h00AA, 16'hBEEF, 1'b1, 1'b0);
    tbl[9]  = mk(16'h0002, 16'h5555, 4'd1, 4'd1, 1'b1, 1'b1, 16'h00AA, 16'hBEEF, 1'b1, 1'b0);
    tbl[10] = mk(16'h0002, 16'h5555, 4'd1, 4'd1, 1'b1, 1'b1, 16'h00AA, 16'hBEEF, 1'b1, 1'b0);
    tbl[11] = mk(16'h0000, 16'h0000, 4'd1, 4'd5, 1'b1, 1'b0, 16'h5555, 16'h00AA, 1'b1, 1'b0);
    tbl[12] = mk(16'h0006, 16'h0F0F, 4'd0, 4'd0, 1'b0, 1'b0, 16'h5555, 16'h00AA, 1'b0, 1'b1);
    tbl[13] = mk(16'h0000, 16'h0000, 4'd1, 4'd2, 1'b1, 1'b0, 16'h0F0F, 16'h0F0F, 1'b1, 1'b1);
    tbl[14] = mk(16'h0010, 16'h1234, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0, 1'b1);
    tbl[15] = mk(16'h0000, 16'h0000, 4'd4, 4'd0, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b1);
    tbl[16] = mk(16'h0001, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b1);
    tbl[17] = mk(16'h0001, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);

    // Power-on reset.
    model_reset();
    #12;
    chk ("reset a.src_data1", a_d1, 16'h0000);
    chk ("reset a.src_data2", a_d2, 16'h0000);
    chk1("reset a.rd_valid", a_v, 1'b0);
    chk1("reset a.onehot_err", a_e, 1'b0);
    chk ("reset b.src_data1", b_d1, 16'h0000);
    chk1("reset b.rd_valid", b_v, 1'b0);
    chk1("reset b.onehot_err", b_e, 1'b0);
    rst_n = 1'b1;

    for (int n = 0; n < NV; n++) begin
      drive(tbl[n].wl, tbl[n].dd, tbl[n].r1, tbl[n].r2, tbl[n].req, tbl[n].st);
      step();
      chk ($sformatf("vec%0d src_data1", n), a_d1, tbl[n].e1);
      chk ($sformatf("vec%0d src_data2", n), a_d2, tbl[n].e2);
      chk1($sformatf("vec%0d rd_valid", n), a_v, tbl[n].ev);
      chk1($sformatf("vec%0d onehot_err", n), a_e, tbl[n].ee);
    end

    // Asynchronous reset in the middle of a read cancels the pending valid and the sticky error.
    drive(16'h0000, 16'h0000, 4'd5, 4'd9, 1'b1, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk1("midreset a.rd_valid", a_v, 1'b0);
    chk ("midreset a.src_data1", a_d1, 16'h0000);
    chk1("midreset a.onehot_err", a_e, 1'b0);
    chk1("midreset b.rd_valid", b_v, 1'b0);
    @(posedge clk);
    #1;
    check_model();
    #3;
    rst_n = 1'b1;
    drive(16'h0000, 16'h0000, 4'd5, 4'd9, 1'b1, 1'b0);
    step();
    chk ("post-reset read src_data1", a_d1, 16'h0000);
    chk ("post-reset read src_data2", a_d2, 16'h0000);
    chk1("post-reset read rd_valid", a_v, 1'b1);

    // Hardwired R0: write then same-edge write+read of id 0.
    drive(16'h0001, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    drive(16'h0001, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    step();
    chk ("zero_r0 b.src_data1", b_d1, 16'h0000);
    chk ("zero_r0 b.src_data2", b_d2, 16'h0000);
    chk1("zero_r0 b.rd_valid", b_v, 1'b1);
    chk1("zero_r0 b.onehot_err", b_e, 1'b0);
    chk ("zero_r0 a.src_data1", a_d1, 16'hFFFF);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] wl;
      int r;
      r = int'($urandom_range(0, 31));
      if (r < 10)      wl = 16'h0000;
      else if (r < 31) wl = 16'h0001 << $urandom_range(0, 15);
      else             wl = 16'($urandom);
      drive(wl, 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_read_port_unit.md
Name: rf_read_port_unit

Overview:
- Register-file storage and read side that consumes the one-hot write wordline produced by the 4-to-16 write decoder.
- Holds 16 x DATA_W registers and provides two registered read ports (rs1/rs2) with a request/valid handshake and stall hold.
- Sits in the decode stage: write-back drives `wordline` and `dst_data`; decode issues `rd_req` and reads `src_data1` and `src_data2` one cycle later.

Parameters:
- DATA_W, 16, width of each register and of every data port.
- ZERO_R0, 0, when 1, register 0 always reads as zero and writes to it are discarded.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wordline  in  16  one-hot write enables from the write decoder; all-zero means no write.
- dst_data  in  DATA_W  write data, qualified by `wordline`.
- src_reg1  in  4  read port 1 register id.
- src_reg2  in  4  read port 2 register id.
- rd_req  in  1  read request, sampled on the clock edge.
- stall  in  1  freeze read outputs and ignore `rd_req`; writes still proceed.
- src_data1  out  DATA_W  registered read data, port 1.
- src_data2  out  DATA_W  registered read data, port 2.
- rd_valid  out  1  high for the cycle after an accepted read.
- onehot_err  out  1  sticky flag, set when `wordline` has more than one bit high.

Behaviour:
- Reset (`rst_n` low, asynchronous): all 16 registers = 0, `src_data1` = `src_data2` = 0, `rd_valid` = 0, `onehot_err` = 0. Reset asserted mid-read cancels any pending `rd_valid`.
- Write: on each posedge, every register i with `wordline[i]` = 1 loads `dst_data`.
  - More than one bit set: all flagged registers are written and `onehot_err` is set; it stays set until reset.
  - ZERO_R0 = 1: `wordline[0]` is ignored for storage but still counted for the one-hot check.
- Read acceptance: a read is accepted at posedge when `rd_req` = 1 and `stall` = 0.
  - Latency is 1 cycle: `src_data1`/`src_data2` load the values of the registers named by `src_reg1`/`src_reg2`, and `rd_valid` = 1 in the following cycle.
- No request: if `rd_req` = 0 and `stall` = 0, `rd_valid` goes to 0 and the data outputs hold their last values.
- Stall: if `stall` = 1, `src_data*` and `rd_valid` hold their current values, `rd_req` is ignored, and the array is still written.
- Same-register reads: `src_reg1` == `src_reg2` is legal; both ports return identical data.
- ZERO_R0 = 1: a read of id 0 returns 0 regardless of bypass.
- Same-edge read and write of the same register (without bypass): the read returns the pre-write value. Bypass behaviour is defined under Optional Feature.
- No other state machine exists; the only sequential state is the array, the output registers, `rd_valid` and `onehot_err`.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: on an accepted read where `wordline[src_regN]` = 1 in the same cycle, `src_dataN` loads `dst_data` (the new value) instead of the array contents. ZERO_R0 still takes precedence for id 0.
- Undefined: no bypass; the read returns the pre-write value, and the new value is visible to reads accepted on later edges.

Decomposition:
- Package rf_pkg:
  - REG_ID_W = 4, NUM_REGS = 16, default DATA_W.
  - Typedef `reg_id_t` (logic [3:0]).
  - Typedef `wordline_t` (logic [15:0]).
- Sub-module rf_read_mux: 16:1 selection of the array by a register id, plus the bypass compare and ZERO_R0 masking; combinational, instantiated twice.
- The top level owns all flops.

Test Plan:
- Reset check: hold `rst_n` low mid-run, then release; issue `rd_req` with ids 5 and 9 -> next cycle `src_data1` = `src_data2` = 0x0000, `rd_valid` = 1; before the request, `rd_valid` = 0 and `onehot_err` = 0.
- Basic write/read: write R3 = 0xBEEF (`wordline` = 0x0008), then next cycle `rd_req` with `src_reg1` = 3, `src_reg2` = 3 -> one cycle later both outputs = 0xBEEF and `rd_valid` pulses for 1 cycle.
- Same-edge write and read of R7 (old value 0x1111, `dst_data` = 0x2222):
  - With RF_WRITE_BYPASS_EN -> `src_data1` = 0x2222.
  - Without the macro -> 0x1111, and a read on the following edge returns 0x2222.
- Stall: with `src_data1` = 0x00AA, assert `stall` for 3 cycles while `rd_req` = 1 and R1 is written with 0x5555 -> outputs and `rd_valid` frozen. Release stall with `src_reg1` = 1 -> the next output is 0x5555.
- One-hot violation: `wordline` = 0x0006 with `dst_data` = 0x0F0F -> R1 = R2 = 0x0F0F and `onehot_err` = 1. It stays 1 through later legal writes and clears only on `rst_n` low.
- ZERO_R0 = 1: write `wordline` = 0x0001 with 0xFFFF, then read id 0 -> 0x0000 (with and without bypass); `onehot_err` stays 0.
